fu_op_sequencer: RTL and testbench

- Multi-cycle issuer that drives the combinational ALU function unit one pass per cycle and collects its Result, Overflow, CarryOut, Negative and Zero outputs.
- Splits 64-bit add and subtract into low-word and high-word passes, chaining the carry between them. Also issues single-pass 32-bit operations.
- Sits between the execute-stage control and the function unit, with valid/ready handshakes on the request and response sides.

---
 rtl/fu_op_sequencer.sv | 269 ++++++++++++++++++++++++++
 tb/tb_fu_op_sequencer.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fu_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : fu_op_sequencer
//  Description : Multi-cycle issuer for a combinational ALU function unit.
//                It issues single-pass 32-bit operations and splits 64-bit
//                ADD/SUB into a low-word pass and a high-word pass, chaining
//                the carry between them. Requests and responses use
//                valid/ready handshakes.
//                Optional feature macro: FU_SEQ_STICKY_OVF_EN adds a sticky
//                overflow flag (ovf_sticky) and its clear input (ovf_clr).
//  Revision    : 1.0 - initial release
// ============================================================================
module fu_op_sequencer #(
    parameter int DATA_WIDTH    = 32,
    parameter int SHIFTER_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    // Request side
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [1:0]                req_op,
    input  logic [3:0]                req_fsel,
    input  logic [SHIFTER_WIDTH-1:0]  req_sh,
    input  logic [2*DATA_WIDTH-1:0]   req_a,
    input  logic [2*DATA_WIDTH-1:0]   req_b,
    // Response side
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [2*DATA_WIDTH-1:0]   rsp_result,
    output logic                      rsp_overflow,
    output logic                      rsp_carry,
    output logic                      rsp_negative,
    output logic                      rsp_zero,
    // Function unit side
    output logic [DATA_WIDTH-1:0]     fu_a,
    output logic [DATA_WIDTH-1:0]     fu_b,
    output logic [3:0]                fu_fsel,
    output logic [SHIFTER_WIDTH-1:0]  fu_sh,
    input  logic [DATA_WIDTH-1:0]     fu_result,
    input  logic                      fu_overflow,
    input  logic                      fu_carry,
    input  logic                      fu_negative,
    input  logic                      fu_zero
`ifdef FU_SEQ_STICKY_OVF_EN
    ,
    output logic                      ovf_sticky,
    input  logic                      ovf_clr
`endif
);

    // Request operation codes
    localparam logic [1:0] c_op_single = 2'd0;
    localparam logic [1:0] c_op_add64  = 2'd1;
    localparam logic [1:0] c_op_sub64  = 2'd2;

    // Function unit selects used by the wide operations
    localparam logic [3:0] c_fsel_pass   = 4'b0000; // transfer A
    localparam logic [3:0] c_fsel_add    = 4'b0010; // A + B
    localparam logic [3:0] c_fsel_add_c  = 4'b0011; // A + B + 1
    localparam logic [3:0] c_fsel_sub_b  = 4'b0100; // A + ~B (borrow pending)
    localparam logic [3:0] c_fsel_sub    = 4'b0101; // A + ~B + 1

    // FIN is the cycle in which captured pass results are composed into the
    // held response registers, giving a registered response one edge after
    // the final pass.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LO   = 3'd1,
        S_HI   = 3'd2,
        S_FIN  = 3'd3,
        S_RESP = 3'd4
    } state_t;

    state_t                     state_q;
    logic [1:0]                 op_q;
    logic [DATA_WIDTH-1:0]      a_hi_q;
    logic [DATA_WIDTH-1:0]      b_hi_q;

    // Captured pass results
    logic [DATA_WIDTH-1:0]      lo_res_q;
    logic                       lo_ovf_q;
    logic                       lo_carry_q;
    logic                       lo_neg_q;
    logic                       lo_zero_q;
    logic [DATA_WIDTH-1:0]      hi_res_q;
    logic                       hi_ovf_q;
    logic                       hi_carry_q;
    logic                       hi_neg_q;
    logic                       hi_zero_q;

    // Registered outputs
    logic                       rsp_valid_q;
    logic [2*DATA_WIDTH-1:0]    rsp_result_q;
    logic                       rsp_ovf_q;
    logic                       rsp_carry_q;
    logic                       rsp_neg_q;
    logic                       rsp_zero_q;
    logic [DATA_WIDTH-1:0]      fu_a_q;
    logic [DATA_WIDTH-1:0]      fu_b_q;
    logic [3:0]                 fu_fsel_q;
    logic [SHIFTER_WIDTH-1:0]   fu_sh_q;

    logic                       w_wide;

    assign w_wide = (op_q == c_op_add64) || (op_q == c_op_sub64);

    // Sequencer FSM: latches the request, loads function unit drives for the
    // coming pass, captures pass results and holds the response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            op_q         <= 2'd0;
            a_hi_q       <= '0;
            b_hi_q       <= '0;
            lo_res_q     <= '0;
            lo_ovf_q     <= 1'b0;
            lo_carry_q   <= 1'b0;
            lo_neg_q     <= 1'b0;
            lo_zero_q    <= 1'b0;
            hi_res_q     <= '0;
            hi_ovf_q     <= 1'b0;
            hi_carry_q   <= 1'b0;
            hi_neg_q     <= 1'b0;
            hi_zero_q    <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_ovf_q    <= 1'b0;
            rsp_carry_q  <= 1'b0;
            rsp_neg_q    <= 1'b0;
            rsp_zero_q   <= 1'b0;
            fu_a_q       <= '0;
            fu_b_q       <= '0;
            fu_fsel_q    <= c_fsel_pass;
            fu_sh_q      <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        op_q   <= req_op;
                        a_hi_q <= req_a[2*DATA_WIDTH-1:DATA_WIDTH];
                        b_hi_q <= req_b[2*DATA_WIDTH-1:DATA_WIDTH];
                        fu_a_q <= req_a[DATA_WIDTH-1:0];
                        fu_b_q <= req_b[DATA_WIDTH-1:0];
                        case (req_op)
                            c_op_single: begin
                                fu_fsel_q <= req_fsel;
                                fu_sh_q   <= req_sh;
                            end
                            c_op_add64: begin
                                fu_fsel_q <= c_fsel_add;
                                fu_sh_q   <= '0;
                            end
                            c_op_sub64: begin
                                fu_fsel_q <= c_fsel_sub;
                                fu_sh_q   <= '0;
                            end
                            default: begin
                                // Reserved op runs as a single pass-through of A
                                fu_fsel_q <= c_fsel_pass;
                                fu_sh_q   <= req_sh;
                            end
                        endcase
                        state_q <= S_LO;
                    end
                end

                S_LO: begin
                    lo_res_q   <= fu_result;
                    lo_ovf_q   <= fu_overflow;
                    lo_carry_q <= fu_carry;
                    lo_neg_q   <= fu_negative;
                    lo_zero_q  <= fu_zero;
                    if (w_wide) begin
                        // High pass selects its carry-in from the low pass carry
                        fu_a_q  <= a_hi_q;
                        fu_b_q  <= b_hi_q;
                        fu_sh_q <= '0;
                        if (op_q == c_op_add64) begin
                            fu_fsel_q <= fu_carry ? c_fsel_add_c : c_fsel_add;
                        end else begin
                            fu_fsel_q <= fu_carry ? c_fsel_sub : c_fsel_sub_b;
                        end
                        state_q <= S_HI;
                    end else begin
                        fu_a_q    <= '0;
                        fu_b_q    <= '0;
                        fu_fsel_q <= c_fsel_pass;
                        fu_sh_q   <= '0;
                        state_q   <= S_FIN;
                    end
                end

                S_HI: begin
                    hi_res_q   <= fu_result;
                    hi_ovf_q   <= fu_overflow;
                    hi_carry_q <= fu_carry;
                    hi_neg_q   <= fu_negative;
                    hi_zero_q  <= fu_zero;
                    fu_a_q     <= '0;
                    fu_b_q     <= '0;
                    fu_fsel_q  <= c_fsel_pass;
                    fu_sh_q    <= '0;
                    state_q    <= S_FIN;
                end

                S_FIN: begin
                    rsp_valid_q <= 1'b1;
                    if (w_wide) begin
                        rsp_result_q <= {hi_res_q, lo_res_q};
                        rsp_ovf_q    <= hi_ovf_q;
                        rsp_carry_q  <= hi_carry_q;
                        rsp_neg_q    <= hi_neg_q;
                        rsp_zero_q   <= lo_zero_q & hi_zero_q;
                    end else begin
                        rsp_result_q <= {{DATA_WIDTH{1'b0}}, lo_res_q};
                        rsp_ovf_q    <= lo_ovf_q;
                        rsp_carry_q  <= lo_carry_q;
                        rsp_neg_q    <= lo_neg_q;
                        rsp_zero_q   <= lo_zero_q;
                    end
                    state_q <= S_RESP;
                end

                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready    = (state_q == S_IDLE);
    assign rsp_valid    = rsp_valid_q;
    assign rsp_result   = rsp_result_q;
    assign rsp_overflow = rsp_ovf_q;
    assign rsp_carry    = rsp_carry_q;
    assign rsp_negative = rsp_neg_q;
    assign rsp_zero     = rsp_zero_q;
    assign fu_a         = fu_a_q;
    assign fu_b         = fu_b_q;
    assign fu_fsel      = fu_fsel_q;
    assign fu_sh        = fu_sh_q;

`ifdef FU_SEQ_STICKY_OVF_EN
    logic ovf_sticky_q;

    // Sticky overflow: set on an overflowing response handshake, set beats clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_sticky_q <= 1'b0;
        end else if (rsp_valid_q && rsp_ready && rsp_ovf_q) begin
            ovf_sticky_q <= 1'b1;
        end else if (ovf_clr) begin
            ovf_sticky_q <= 1'b0;
        end
    end

    assign ovf_sticky = ovf_sticky_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fu_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fu_op_sequencer
//  Description : Self-checking bench for fu_op_sequencer with a behavioural
//                ALU function unit and a 64-bit arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fu_op_sequencer;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [3:0]  req_fsel;
    logic [4:0]  req_sh;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_result;
    logic        rsp_overflow;
    logic        rsp_carry;
    logic        rsp_negative;
    logic        rsp_zero;
    logic [31:0] fu_a;
    logic [31:0] fu_b;
    logic [3:0]  fu_fsel;
    logic [4:0]  fu_sh;
    logic [31:0] fu_result;
    logic        fu_overflow;
    logic        fu_carry;
    logic        fu_negative;
    logic        fu_zero;
`ifdef FU_SEQ_STICKY_OVF_EN
    logic        ovf_sticky;
    logic        ovf_clr;
    logic        sticky_m;
`endif

    int errors = 0;
    int checks = 0;

    fu_op_sequencer #(.DATA_WIDTH(32), .SHIFTER_WIDTH(5)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_fsel     (req_fsel),
        .req_sh       (req_sh),
        .req_a        (req_a),
        .req_b        (req_b),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_overflow (rsp_overflow),
        .rsp_carry    (rsp_carry),
        .rsp_negative (rsp_negative),
        .rsp_zero     (rsp_zero),
        .fu_a         (fu_a),
        .fu_b         (fu_b),
        .fu_fsel      (fu_fsel),
        .fu_sh        (fu_sh),
        .fu_result    (fu_result),
        .fu_overflow  (fu_overflow),
        .fu_carry     (fu_carry),
        .fu_negative  (fu_negative),
        .fu_zero      (fu_zero)
`ifdef FU_SEQ_STICKY_OVF_EN
        ,
        .ovf_sticky   (ovf_sticky),
        .ovf_clr      (ovf_clr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural combinational ALU function unit
    typedef struct packed {
        logic [31:0] res;
        logic        ovf;
        logic        carry;
        logic        neg;
        logic        zero;
    } fu_t;

    function automatic fu_t fu_eval(input logic [31:0] a, input logic [31:0] b,
                                    input logic [3:0] fsel, input logic [4:0] sh);
        fu_t         r;
        logic [32:0] s;
        logic [31:0] y;
        logic        cin;
        logic        arith;
        r     = '0;
        arith = 1'b1;
        y     = 32'd0;
        cin   = 1'b0;
        case (fsel)
            4'd0:  begin arith = 1'b0; r.res = a; end
            4'd1:  begin y = 32'd0; cin = 1'b1; end
            4'd2:  begin y = b; end
            4'd3:  begin y = b; cin = 1'b1; end
            4'd4:  begin y = ~b; end
            4'd5:  begin y = ~b; cin = 1'b1; end
            4'd6:  begin y = 32'hFFFF_FFFF; end
            4'd7:  begin arith = 1'b0; r.res = a; end
            4'd8:  begin arith = 1'b0; r.res = a & b; end
            4'd9:  begin arith = 1'b0; r.res = a | b; end
            4'd10: begin arith = 1'b0; r.res = a ^ b; end
            4'd11: begin arith = 1'b0; r.res = ~a; end
            4'd12: begin arith = 1'b0; r.res = b; end
            4'd13: begin arith = 1'b0; r.res = a >> sh; end
            4'd14: begin arith = 1'b0; r.res = a << sh; end
            default: begin arith = 1'b0; r.res = 32'd0; end
        endcase
        if (arith) begin
            s       = {1'b0, a} + {1'b0, y} + {32'd0, cin};
            r.res   = s[31:0];
            r.carry = s[32];
            r.ovf   = (a[31] == y[31]) && (s[31] != a[31]);
        end
        r.neg  = r.res[31];
        r.zero = (r.res == 32'd0);
        return r;
    endfunction

    fu_t fu_out;
    always_comb fu_out = fu_eval(fu_a, fu_b, fu_fsel, fu_sh);
    assign fu_result   = fu_out.res;
    assign fu_overflow = fu_out.ovf;
    assign fu_carry    = fu_out.carry;
    assign fu_negative = fu_out.neg;
    assign fu_zero     = fu_out.zero;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready_wait", {63'd0, req_ready}, 64'd1);
    endtask

    // One full transaction: reference model, per-pass drive checks,
    // latency, hold stability and handshake.
    task automatic do_txn(input logic [1:0] op, input logic [3:0] fsel, input logic [4:0] sh,
                          input logic [63:0] a, input logic [63:0] b, input int hold);
        logic [63:0] e_res;
        logic [3:0]  e_flags;
        logic [3:0]  e_lo_fsel;
        logic [3:0]  e_hi_fsel;
        logic [4:0]  e_lo_sh;
        logic [3:0]  fs;
        logic [64:0] s;
        logic        wide;
        fu_t         r;

        wide      = (op == 2'd1) || (op == 2'd2);
        e_hi_fsel = 4'd0;
        if (op == 2'd1) begin
            s         = {1'b0, a} + {1'b0, b};
            e_res     = s[63:0];
            e_flags   = {(a[63] == b[63]) && (s[63] != a[63]), s[64], s[63], s[63:0] == 64'd0};
            e_lo_fsel = 4'b0010;
            e_lo_sh   = 5'd0;
            e_hi_fsel = (({1'b0, a[31:0]} + {1'b0, b[31:0]}) > 33'h0_FFFF_FFFF) ? 4'b0011 : 4'b0010;
        end else if (op == 2'd2) begin
            s         = {1'b0, a} + {1'b0, ~b} + 65'd1;
            e_res     = s[63:0];
            e_flags   = {(a[63] != b[63]) && (s[63] != a[63]), s[64], s[63], s[63:0] == 64'd0};
            e_lo_fsel = 4'b0101;
            e_lo_sh   = 5'd0;
            e_hi_fsel = (a[31:0] >= b[31:0]) ? 4'b0101 : 4'b0100;
        end else begin
            fs        = (op == 2'd3) ? 4'd0 : fsel;
            r         = fu_eval(a[31:0], b[31:0], fs, sh);
            e_res     = {32'd0, r.res};
            e_flags   = {r.ovf, r.carry, r.neg, r.zero};
            e_lo_fsel = fs;
            e_lo_sh   = sh;
        end

        wait_ready();
        req_op    = op;
        req_fsel  = fsel;
        req_sh    = sh;
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        // LO pass
        chk("lo_fsel", {60'd0, fu_fsel}, {60'd0, e_lo_fsel});
        chk("lo_sh", {59'd0, fu_sh}, {59'd0, e_lo_sh});
        chk("lo_a", {32'd0, fu_a}, {32'd0, a[31:0]});
        chk("lo_b", {32'd0, fu_b}, {32'd0, b[31:0]});
        chk("busy_ready", {63'd0, req_ready}, 64'd0);
        if (wide) begin
            @(negedge clk);
            chk("hi_fsel", {60'd0, fu_fsel}, {60'd0, e_hi_fsel});
            chk("hi_sh", {59'd0, fu_sh}, 64'd0);
            chk("hi_a", {32'd0, fu_a}, {32'd0, a[63:32]});
            chk("hi_b", {32'd0, fu_b}, {32'd0, b[63:32]});
        end
        @(negedge clk);
        chk("rsp_valid_early", {63'd0, rsp_valid}, 64'd0);
        @(negedge clk);
        chk("rsp_valid_latency", {63'd0, rsp_valid}, 64'd1);
        chk("rsp_result", rsp_result, e_res);
        chk("rsp_flags", {60'd0, rsp_overflow, rsp_carry, rsp_negative, rsp_zero}, {60'd0, e_flags});
        chk("resp_fu_fsel", {60'd0, fu_fsel}, 64'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", {63'd0, rsp_valid}, 64'd1);
            chk("hold_result", rsp_result, e_res);
            chk("hold_flags", {60'd0, rsp_overflow, rsp_carry, rsp_negative, rsp_zero}, {60'd0, e_flags});
            chk("hold_req_ready", {63'd0, req_ready}, 64'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("post_hs_valid", {63'd0, rsp_valid}, 64'd0);
        chk("post_hs_ready", {63'd0, req_ready}, 64'd1);
`ifdef FU_SEQ_STICKY_OVF_EN
        if (e_flags[3]) sticky_m = 1'b1;
        chk("ovf_sticky", {63'd0, ovf_sticky}, {63'd0, sticky_m});
`endif
    endtask

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] ra;
        logic [63:0] rb;
        logic [63:0] edge_vals [0:5];
        edge_vals[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        edge_vals[1] = 64'h7FFF_FFFF_FFFF_FFFF;
        edge_vals[2] = 64'h8000_0000_0000_0000;
        edge_vals[3] = 64'h0000_0000_FFFF_FFFF;
        edge_vals[4] = 64'h0000_0001_0000_0000;
        edge_vals[5] = 64'd0;

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_op    = 2'd0;
        req_fsel  = 4'd0;
        req_sh    = 5'd0;
        req_a     = 64'd0;
        req_b     = 64'd0;
        rsp_ready = 1'b0;
`ifdef FU_SEQ_STICKY_OVF_EN
        ovf_clr   = 1'b0;
        sticky_m  = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("reset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("reset_rsp_result", rsp_result, 64'd0);
        chk("reset_flags", {60'd0, rsp_overflow, rsp_carry, rsp_negative, rsp_zero}, 64'd0);
        chk("reset_req_ready", {63'd0, req_ready}, 64'd1);
        chk("reset_fu", {fu_a, fu_b[22:0], fu_fsel, fu_sh}, 64'd0);
`ifdef FU_SEQ_STICKY_OVF_EN
        chk("reset_sticky", {63'd0, ovf_sticky}, 64'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases
        do_txn(2'd1, 4'd0, 5'd0, 64'h0000_0000_FFFF_FFFF, 64'd1, 1);
        do_txn(2'd1, 4'd0, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0);
        do_txn(2'd1, 4'd0, 5'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 2);
`ifdef FU_SEQ_STICKY_OVF_EN
        repeat (2) @(negedge clk);
        chk("sticky_held", {63'd0, ovf_sticky}, 64'd1);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr  = 1'b0;
        sticky_m = 1'b0;
        chk("sticky_cleared", {63'd0, ovf_sticky}, 64'd0);
`endif
        do_txn(2'd2, 4'd0, 5'd0, 64'h0000_0001_0000_0000, 64'd1, 0);
        do_txn(2'd0, 4'b1110, 5'd4, 64'h0000_0000_0000_000F, 64'd0, 5);
        do_txn(2'd3, 4'b1110, 5'd4, 64'h1234_5678_9ABC_DEF0, 64'h55, 1);
        do_txn(2'd2, 4'd0, 5'd0, 64'h8000_0000_0000_0000, 64'd1, 0);

        // Reset during the HI pass of an ADD64
        wait_ready();
        req_op    = 2'd1;
        req_a     = 64'h0000_0000_FFFF_FFFF;
        req_b     = 64'd1;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_hi_fsel", {60'd0, fu_fsel}, 64'b0011);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("mid_rst_req_ready", {63'd0, req_ready}, 64'd1);
        chk("mid_rst_fu_fsel", {60'd0, fu_fsel}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_req_ready", {63'd0, req_ready}, 64'd1);
        chk("post_rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        do_txn(2'd1, 4'd0, 5'd0, 64'h0000_0002_8000_0000, 64'h0000_0003_8000_0000, 0);

        // Randomized traffic with boundary-biased operands
        for (int k = 0; k < 40; k++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if ($urandom_range(0, 2) == 0) ra = edge_vals[$urandom_range(0, 5)];
            if ($urandom_range(0, 2) == 0) rb = edge_vals[$urandom_range(0, 5)];
            do_txn(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                   5'($urandom_range(0, 31)), ra, rb, $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
